// File: rtl/vga_draw_pkg.sv
// Shared drawing definitions for the VGA overlay blocks: coordinate width,
// 6-bit colour type, named colours and the bar-gauge state encoding.
package vga_draw_pkg;

  localparam int COORD_W = 9;

  typedef logic [5:0] colour_t;

  localparam colour_t GREEN_BAR = 6'b001001;
  localparam colour_t WHITE     = 6'b111111;
  localparam colour_t BLACK     = 6'b000000;

  typedef enum logic [2:0] {
    IDLE,
    SEG_FILL,
    SEG_ERASE,
    CLR,
    STEP,
    DONE
  } gauge_state_t;

  // Width of a counter able to hold 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vga_rect_scan.sv
// Walks a filled rectangle one pixel per clock, x inner and y outer, raising
// plot for every pixel and last on the final one.
module vga_rect_scan
  import vga_draw_pkg::*;
#(
  parameter int            CW         = COORD_W,
  parameter int            MAX_W      = 300,
  parameter int            MAX_H      = 5,
  parameter int            WW         = cnt_w(MAX_W),
  parameter int            HW         = cnt_w(MAX_H),
  parameter logic [CW-1:0] RST_X      = '0,
  parameter logic [CW-1:0] RST_Y      = '0,
  parameter colour_t       RST_COLOUR = WHITE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [CW-1:0] x0_i,
  input  logic [CW-1:0] y0_i,
  input  logic [WW-1:0] w_i,
  input  logic [HW-1:0] h_i,
  input  colour_t       colour_i,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output colour_t       colour_o,
  output logic          plot_o,
  output logic          last_o
);

  logic [CW-1:0] x_q, y_q, x_base_q;
  colour_t       colour_q;
  logic          plot_q;
  logic [WW-1:0] w_q, cnt_x_q;
  logic [HW-1:0] h_q, cnt_y_q;
  logic          row_end;
  logic          last;

  assign row_end = (cnt_x_q == w_q - WW'(1));
  assign last    = plot_q && row_end && (cnt_y_q == h_q - HW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q      <= RST_X;
      y_q      <= RST_Y;
      x_base_q <= RST_X;
      colour_q <= RST_COLOUR;
      plot_q   <= 1'b0;
      w_q      <= WW'(1);
      h_q      <= HW'(1);
      cnt_x_q  <= '0;
      cnt_y_q  <= '0;
    end else if (start_i) begin
      x_q      <= x0_i;
      y_q      <= y0_i;
      x_base_q <= x0_i;
      colour_q <= colour_i;
      w_q      <= w_i;
      h_q      <= h_i;
      cnt_x_q  <= '0;
      cnt_y_q  <= '0;
      plot_q   <= 1'b1;
    end else if (plot_q) begin
      // Coordinates freeze on the last pixel so they hold while plot is low.
      if (last) begin
        plot_q <= 1'b0;
      end else if (row_end) begin
        cnt_x_q <= '0;
        x_q     <= x_base_q;
        cnt_y_q <= cnt_y_q + HW'(1);
        y_q     <= y_q + CW'(1);
      end else begin
        cnt_x_q <= cnt_x_q + WW'(1);
        x_q     <= x_q + CW'(1);
      end
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign colour_o = colour_q;
  assign plot_o   = plot_q;
  assign last_o   = last;

endmodule

// File: rtl/vga_bar_gauge.sv
// Segmented bar gauge drawn straight into a framebuffer: fills, erases,
// steps to a target level or clears the whole bar, one pixel per clock.
module vga_bar_gauge #(
  parameter int         X0        = 10,
  parameter int         Y0        = 44,
  parameter int         SEG_W     = 10,
  parameter int         SEG_H     = 5,
  parameter int         MAX_SEGS  = 30,
  parameter logic [5:0] FG_COLOUR = vga_draw_pkg::GREEN_BAR,
  parameter logic [5:0] BG_COLOUR = vga_draw_pkg::WHITE,
  parameter int         COORD_W   = vga_draw_pkg::COORD_W,
  localparam int        LW        = $clog2(MAX_SEGS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  input  logic               clear,
  input  logic               set_req,
  input  logic [LW-1:0]      set_level,
  output logic [LW-1:0]      level,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [5:0]         colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  import vga_draw_pkg::*;

  localparam int                 FULL_W  = MAX_SEGS * SEG_W;
  localparam int                 SCAN_WW = cnt_w(FULL_W);
  localparam int                 SCAN_HW = cnt_w(SEG_H);
  localparam logic [LW-1:0]      MAX_L   = LW'(MAX_SEGS);
  localparam logic [COORD_W-1:0] X0_C    = COORD_W'(X0);
  localparam logic [COORD_W-1:0] Y0_C    = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] SEG_W_C = COORD_W'(SEG_W);

  if ((X0 + MAX_SEGS * SEG_W > 2 ** COORD_W) || (Y0 + SEG_H > 2 ** COORD_W)) begin : g_geom_check
    $error("vga_bar_gauge: bar rectangle does not fit in COORD_W-bit coordinates");
  end

  gauge_state_t        state_q, state_d;
  logic [LW-1:0]       level_q, level_d;
  logic [LW-1:0]       target_q, target_d;
  logic                launch_q, launch_d;
  logic [LW-1:0]       set_tgt;
  logic [LW-1:0]       seg_idx;
  logic                scan_start;
  logic                scan_clear;
  colour_t             scan_colour;
  logic                scan_last;
  logic [COORD_W-1:0]  seg_x;
  logic [COORD_W-1:0]  scan_x0;
  logic [SCAN_WW-1:0]  scan_w;

  assign set_tgt = (set_level > MAX_L) ? MAX_L : set_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      level_q  <= '0;
      target_q <= '0;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      launch_q <= launch_d;
    end
  end

  // launch_q marks the cycle right after a request is taken: the scanner is
  // primed then, so plot/busy/done all surface one edge later.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    target_d    = target_q;
    launch_d    = 1'b0;
    scan_start  = 1'b0;
    scan_clear  = 1'b0;
    scan_colour = FG_COLOUR;
    seg_idx     = level_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          launch_d = 1'b1;
          target_d = '0;
          state_d  = CLR;
        end else if (set_req) begin
          launch_d = 1'b1;
          target_d = set_tgt;
          state_d  = (set_tgt == level_q) ? DONE : STEP;
        end else if (inc) begin
          launch_d = 1'b1;
          if (level_q < MAX_L) begin
            target_d = level_q + LW'(1);
            state_d  = SEG_FILL;
          end else begin
            state_d = DONE;
          end
        end else if (dec) begin
          launch_d = 1'b1;
          if (level_q != '0) begin
            target_d = level_q - LW'(1);
            state_d  = SEG_ERASE;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEG_FILL: begin
        scan_start = launch_q;
        if (scan_last) begin
          level_d = level_q + LW'(1);
          state_d = (level_q + LW'(1) == target_q) ? DONE : STEP;
        end
      end
      SEG_ERASE: begin
        scan_start  = launch_q;
        scan_colour = BG_COLOUR;
        seg_idx     = level_q - LW'(1);
        if (scan_last) begin
          level_d = level_q - LW'(1);
          state_d = (level_q - LW'(1) == target_q) ? DONE : STEP;
        end
      end
      CLR: begin
        scan_start  = launch_q;
        scan_clear  = 1'b1;
        scan_colour = BG_COLOUR;
        if (scan_last) begin
          level_d = '0;
          state_d = DONE;
        end
      end
      STEP: begin
        // Only entered with level != target, so a segment always follows.
        scan_start = 1'b1;
        if (target_q > level_q) begin
          state_d = SEG_FILL;
        end else begin
          scan_colour = BG_COLOUR;
          seg_idx     = level_q - LW'(1);
          state_d     = SEG_ERASE;
        end
      end
      DONE: begin
        if (!launch_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign seg_x   = X0_C + COORD_W'(seg_idx) * SEG_W_C;
  assign scan_x0 = scan_clear ? X0_C : seg_x;
  assign scan_w  = scan_clear ? SCAN_WW'(FULL_W) : SCAN_WW'(SEG_W);

  vga_rect_scan #(
    .CW        (COORD_W),
    .MAX_W     (FULL_W),
    .MAX_H     (SEG_H),
    .WW        (SCAN_WW),
    .HW        (SCAN_HW),
    .RST_X     (X0_C),
    .RST_Y     (Y0_C),
    .RST_COLOUR(BG_COLOUR)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .start_i (scan_start),
    .x0_i    (scan_x0),
    .y0_i    (Y0_C),
    .w_i     (scan_w),
    .h_i     (SCAN_HW'(SEG_H)),
    .colour_i(scan_colour),
    .x_o     (x),
    .y_o     (y),
    .colour_o(colour),
    .plot_o  (plot),
    .last_o  (scan_last)
  );

  assign level = level_q;
  assign busy  = (state_q != IDLE) && !launch_q;
  assign done  = (state_q == DONE) && !launch_q;

endmodule

// File: doc/vga_bar_gauge.md
VGA_BAR_GAUGE -- requirements
Module: vga_bar_gauge

Interface
REQ-001 The module SHALL have parameter X0, default 10, meaning left pixel column of the bar.
REQ-002 The module SHALL have parameter Y0, default 44, meaning top pixel row of the bar.
REQ-003 The module SHALL have parameter SEG_W, default 10, meaning segment width in pixels.
REQ-004 The module SHALL have parameter SEG_H, default 5, meaning segment height in pixels.
REQ-005 The module SHALL have parameter MAX_SEGS, default 30, meaning number of segments at full scale.
REQ-006 The module SHALL have parameters FG_COLOUR (6'b001001, filled) and BG_COLOUR (6'b111111, empty).
REQ-007 The module SHALL have parameter COORD_W, default 9, meaning x/y width.
REQ-008 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-009 The module SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-010 The module SHALL have port inc, input, 1 bit, request to add one segment.
REQ-011 The module SHALL have port dec, input, 1 bit, request to remove one segment.
REQ-012 The module SHALL have port clear, input, 1 bit, request to erase the whole bar and zero the level.
REQ-013 The module SHALL have ports set_req, input, 1 bit, and set_level, input, LW = $clog2(MAX_SEGS+1) bits, a request to step to a target level.
REQ-014 The module SHALL have port level, output, LW bits, holding the current segment count.
REQ-015 The module SHALL have ports x and y, output, COORD_W bits each, the registered pixel coordinate.
REQ-016 The module SHALL have port colour, output, 6 bits, the registered pixel colour.
REQ-017 The module SHALL have port plot, output, 1 bit; it is the framebuffer write strobe, and x/y/colour are valid when it is high.
REQ-018 The module SHALL have ports busy, output, 1 bit, and done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have states IDLE, SEG_FILL, SEG_ERASE, CLR, STEP, and DONE.
REQ-020 Requests SHALL be sampled only in IDLE, with priority clear > set_req > inc > dec; requests arriving while busy=1 SHALL be dropped.
REQ-021 inc with level<MAX_SEGS SHALL go to SEG_FILL and draw segment index=level in FG_COLOUR; level SHALL increment in the DONE cycle.
REQ-022 dec with level>0 SHALL go to SEG_ERASE and draw segment index=level-1 in BG_COLOUR; level SHALL decrement in the DONE cycle.
REQ-023 inc at level=MAX_SEGS, dec at level=0, and set_req with set_level==level SHALL go straight to DONE: no plot, level unchanged.
REQ-024 set_level>MAX_SEGS SHALL be clamped to MAX_SEGS.
REQ-025 set_req SHALL latch the target and repeatedly fill or erase one segment via STEP until level==target, then go to DONE with a single done pulse.
REQ-026 clear SHALL scan the rectangle X0..X0+MAX_SEGS*SEG_W-1 by Y0..Y0+SEG_H-1 in BG_COLOUR, then set level=0.
REQ-027 Segment i SHALL occupy x = X0+i*SEG_W .. +SEG_W-1 and y = Y0 .. Y0+SEG_H-1.
REQ-028 Pixel scan order SHALL be x inner and y outer, one pixel per cycle, with no gaps within a rectangle.
REQ-029 Timing: for a request sampled at edge k, plot, busy, and the first pixel SHALL appear after edge k+1.
REQ-030 A segment SHALL take exactly SEG_W*SEG_H plot cycles; a clear SHALL take MAX_SEGS*SEG_W*SEG_H plot cycles.
REQ-031 In STEP, consecutive segments SHALL be separated by exactly one non-plot cycle.
REQ-032 done SHALL be high for exactly one cycle, immediately after the last pixel (or after edge k+1 in the no-draw case).
REQ-033 busy SHALL be high from after edge k+1 through the done cycle inclusive; IDLE SHALL accept a new request on the edge ending done.
REQ-034 When plot=0, x, y, and colour SHALL hold their last values.
REQ-035 Pixel counters SHALL be $clog2-sized; elaboration SHALL fail if X0+MAX_SEGS*SEG_W > 2**COORD_W or Y0+SEG_H > 2**COORD_W.

Reset
REQ-036 On reset asserted, the block SHALL immediately, independent of clk, enter IDLE, mid-scan included, with plot=0, busy=0, done=0, level=0, x=X0, y=Y0, colour=BG_COLOUR, and the latched target cleared.
REQ-037 After reset deasserts, the first request SHALL be sampled on the first rising edge.

Structure
REQ-038 A shared package vga_draw_pkg SHALL hold COORD_W, the colour type (6-bit), and named colour constants (GREEN_BAR, WHITE, BLACK).
REQ-039 One sub-module vga_rect_scan SHALL take origin, width, height, colour, and start, produce x/y/colour/plot/last, and be reused for segment and clear scans.

Verification
REQ-040 Reset, then inc -> 50 plot cycles covering x 10..19 and y 44..48 in colour 001001, done pulse, level=1.
REQ-041 30 incs, then a 31st inc -> no plot, done after 1 cycle, level stays 30; dec at level 0 likewise leaves level 0.
REQ-042 At level 7, clear -> 1500 plot cycles covering x 10..309 and y 44..48 in colour 111111, then level=0.
REQ-043 At level 5, set_req with set_level=3 -> erase x 50..59 then x 40..49, 100 plot cycles, one done pulse, level=3; set_level=31 clamps to 30.
REQ-044 inc and clear asserted in the same IDLE cycle -> clear executes; inc pulsed while busy -> ignored, level unchanged.
REQ-045 Reset asserted at pixel 20 of a segment -> plot=0 and level=0 without waiting for a clk edge; a following inc draws segment 0.
